// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef struct packed {
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_REL  = 8'hF0;
    localparam logic [7:0] CODE_ACK  = 8'hFA;
    localparam logic [7:0] CODE_ECHO = 8'hEE;
    localparam logic [7:0] CODE_BAT  = 8'hAA;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_F12    = 8'h07;
    localparam logic [7:0] SC_DEL    = 8'h71;

    // Keyboard status replies that never represent a key.
    function automatic logic is_dropped(input logic [7:0] code);
        return (code == CODE_ACK) || (code == CODE_ECHO) || (code == CODE_BAT);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, clock glitch filter, inter-edge timeout and 11-bit frame checker.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 42000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       kbd_cc_i,
    input  logic       kbd_dd_i,
    output logic [7:0] byte_o,
    output logic       byte_stb_o,
    output logic       err_stb_o
);

    localparam longint TO_CYCLES = (longint'(CLK_HZ) * longint'(TIMEOUT_US)) / 64'sd1000000;
    localparam int     TO_W      = $clog2(TO_CYCLES + 1);
    localparam int     FW        = $clog2(FILTER_LEN);
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TO_CYCLES);
    localparam logic [FW-1:0]   FLT_LAST  = FW'(FILTER_LEN - 1);

    logic [1:0]      meta_q, sync_q;
    logic            filt_q, filt_d;
    logic [FW-1:0]   flt_cnt_q, flt_cnt_d;
    logic [TO_W-1:0] to_q, to_d;
    frame_state_t    state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_stb_q, byte_stb_d;
    logic            err_stb_q, err_stb_d;
    logic            fall_evt;
    logic            dd_s;

    // Lines idle high, so the synchroniser and filter come out of reset high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            filt_q     <= 1'b1;
            flt_cnt_q  <= '0;
            to_q       <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            byte_q     <= '0;
            byte_stb_q <= 1'b0;
            err_stb_q  <= 1'b0;
        end else begin
            meta_q     <= {kbd_dd_i, kbd_cc_i};
            sync_q     <= meta_q;
            filt_q     <= filt_d;
            flt_cnt_q  <= flt_cnt_d;
            to_q       <= to_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            byte_q     <= byte_d;
            byte_stb_q <= byte_stb_d;
            err_stb_q  <= err_stb_d;
        end
    end

    assign dd_s     = sync_q[1];
    assign fall_evt = filt_q & ~sync_q[0] & (flt_cnt_q == FLT_LAST);

    always_comb begin
        filt_d     = filt_q;
        flt_cnt_d  = '0;
        to_d       = (to_q != '0) ? to_q - 1'b1 : '0;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_d     = byte_q;
        byte_stb_d = 1'b0;
        err_stb_d  = 1'b0;

        if (sync_q[0] != filt_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                filt_d = sync_q[0];
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end

        if (fall_evt) begin
            to_d = TO_RELOAD;
            unique case (state_q)
                ST_IDLE: begin
                    if (!dd_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dd_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dd_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (dd_s && (^{shift_q, par_q})) begin
                        byte_d     = shift_q;
                        byte_stb_d = 1'b1;
                    end else begin
                        err_stb_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if ((to_q == '0) && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    assign byte_o     = byte_q;
    assign byte_stb_o = byte_stb_q;
    assign err_stb_o  = err_stb_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: prefix folding, modifier tracking, event FIFO and interrupt.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 42000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK42,
    input  logic       RST,
    input  logic       KBD_CC,
    input  logic       KBD_DD,
    input  logic       RD,
    output logic [9:0] DATA,
    output logic       VALID,
    output logic       OVF,
    output logic       PERR,
    input  logic       CLR_ERR,
    output logic       KB_CTRL,
    output logic       KB_ALT,
    output logic       KB_SH,
    output logic       KB_F12,
    output logic       KB_RESET,
    input  logic       INT_ENA,
    output logic       INT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0] rx_byte;
    logic       rx_stb, rx_err;

    ps2_frame_rx #(
        .CLK_HZ    (CLK_HZ),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_US(TIMEOUT_US)
    ) u_frame (
        .clk_i     (CLK42),
        .rst_i     (RST),
        .kbd_cc_i  (KBD_CC),
        .kbd_dd_i  (KBD_DD),
        .byte_o    (rx_byte),
        .byte_stb_o(rx_stb),
        .err_stb_o (rx_err)
    );

    ps2_evt_t        mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ext_q, ext_d, rel_q, rel_d;
    logic            sh_q, sh_d, ctrl_q, ctrl_d, alt_q, alt_d, f12_q, f12_d, del_q, del_d;
    logic            ovf_q, ovf_d, perr_q, perr_d, int_q;
    logic            push_req, do_push, pop, full, valid;
    ps2_evt_t        push_evt;

    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = RD & valid;

    always_comb begin
        ext_d         = ext_q;
        rel_d         = rel_q;
        sh_d          = sh_q;
        ctrl_d        = ctrl_q;
        alt_d         = alt_q;
        f12_d         = f12_q;
        del_d         = del_q;
        push_req      = 1'b0;
        push_evt.rel  = rel_q;
        push_evt.ext  = ext_q;
        push_evt.code = rx_byte;

        if (rx_err) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (rx_stb) begin
            if (rx_byte == CODE_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == CODE_REL) begin
                rel_d = 1'b1;
            end else if (!is_dropped(rx_byte)) begin
                push_req = 1'b1;
                ext_d    = 1'b0;
                rel_d    = 1'b0;
                // Modifier state follows the key even if the event itself is lost.
                if (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT) sh_d = ~rel_q;
                if (rx_byte == SC_CTRL)                           ctrl_d = ~rel_q;
                if (rx_byte == SC_ALT)                            alt_d = ~rel_q;
                if (rx_byte == SC_F12 && !ext_q)                  f12_d = ~rel_q;
                if (rx_byte == SC_DEL && ext_q)                   del_d = ~rel_q;
            end
        end

        do_push = push_req & (~full | pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + CW'(do_push) - CW'(pop);

        ovf_d = ovf_q;
        if (push_req && full && !pop) ovf_d = 1'b1;
        else if (CLR_ERR)             ovf_d = 1'b0;

        perr_d = perr_q;
        if (rx_err)       perr_d = 1'b1;
        else if (CLR_ERR) perr_d = 1'b0;
    end

    always_ff @(posedge CLK42 or posedge RST) begin
        if (RST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            sh_q    <= 1'b0;
            ctrl_q  <= 1'b0;
            alt_q   <= 1'b0;
            f12_q   <= 1'b0;
            del_q   <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ext_q   <= ext_d;
            rel_q   <= rel_d;
            sh_q    <= sh_d;
            ctrl_q  <= ctrl_d;
            alt_q   <= alt_d;
            f12_q   <= f12_d;
            del_q   <= del_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            int_q   <= INT_ENA & valid;
        end
    end

    always_ff @(posedge CLK42) begin
        if (do_push) mem[wr_q] <= push_evt;
    end

    // Storage is not reset, so the head is masked while the queue is empty.
    assign DATA     = valid ? mem[rd_q] : '0;
    assign VALID    = valid;
    assign OVF      = ovf_q;
    assign PERR     = perr_q;
    assign KB_CTRL  = ctrl_q;
    assign KB_ALT   = alt_q;
    assign KB_SH    = sh_q;
    assign KB_F12   = f12_q;
    assign KB_RESET = ctrl_q & alt_q & del_q;
    assign INT      = int_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Randomised and directed bench for ps2_scan_rx against a frame-level event model.
module tb_ps2_scan_rx;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbd_cc = 1'b1;
    logic       kbd_dd = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic       int_ena = 1'b0;
    logic [9:0] data;
    logic       valid, ovf, perr, kb_ctrl, kb_alt, kb_sh, kb_f12, kb_reset, irq;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_scan_rx #(
        .CLK_HZ    (1000000),
        .FILTER_LEN(8),
        .TIMEOUT_US(400),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK42   (clk),
        .RST     (rst),
        .KBD_CC  (kbd_cc),
        .KBD_DD  (kbd_dd),
        .RD      (rd),
        .DATA    (data),
        .VALID   (valid),
        .OVF     (ovf),
        .PERR    (perr),
        .CLR_ERR (clr_err),
        .KB_CTRL (kb_ctrl),
        .KB_ALT  (kb_alt),
        .KB_SH   (kb_sh),
        .KB_F12  (kb_f12),
        .KB_RESET(kb_reset),
        .INT_ENA (int_ena),
        .INT     (irq)
    );

    always #5 clk = ~clk;

    // Reference model: queue of events plus key/flag state.
    logic [9:0] m_q[$];
    bit m_ext, m_rel, m_sh, m_ctrl, m_alt, m_f12, m_del, m_ovf, m_perr;

    task automatic model_reset();
        m_q.delete();
        m_ext = 0; m_rel = 0; m_sh = 0; m_ctrl = 0; m_alt = 0;
        m_f12 = 0; m_del = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic model_byte(input logic [7:0] c, input bit good);
        bit make;
        if (!good) begin
            m_perr = 1; m_ext = 0; m_rel = 0;
            return;
        end
        if (c == 8'hE0) m_ext = 1;
        else if (c == 8'hF0) m_rel = 1;
        else if (c == 8'hFA || c == 8'hEE || c == 8'hAA) begin
        end else begin
            if (m_q.size() < DEPTH) m_q.push_back({m_rel, m_ext, c});
            else m_ovf = 1;
            make = !m_rel;
            if (c == 8'h12 || c == 8'h59) m_sh = make;
            if (c == 8'h14) m_ctrl = make;
            if (c == 8'h11) m_alt = make;
            if (c == 8'h07 && !m_ext) m_f12 = make;
            if (c == 8'h71 && m_ext) m_del = make;
            m_ext = 0; m_rel = 0;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [9:0] exp_data;
        exp_data = (m_q.size() != 0) ? m_q[0] : 10'h000;
        check_val({tag, ".valid"}, 32'(valid), 32'(m_q.size() != 0));
        check_val({tag, ".data"}, 32'(data), 32'(exp_data));
        check_val({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        check_val({tag, ".perr"}, 32'(perr), 32'(m_perr));
        check_val({tag, ".ctrl"}, 32'(kb_ctrl), 32'(m_ctrl));
        check_val({tag, ".alt"}, 32'(kb_alt), 32'(m_alt));
        check_val({tag, ".sh"}, 32'(kb_sh), 32'(m_sh));
        check_val({tag, ".f12"}, 32'(kb_f12), 32'(m_f12));
        check_val({tag, ".kbreset"}, 32'(kb_reset), 32'(m_ctrl & m_alt & m_del));
        check_val({tag, ".int"}, 32'(irq), 32'(int_ena && (m_q.size() != 0)));
    endtask

    task automatic send_bit(input logic v);
        kbd_dd = v;
        repeat (8) @(negedge clk);
        kbd_cc = 1'b0;
        repeat (16) @(negedge clk);
        kbd_cc = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b, input bit bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad);
        send_bit(1'b1);
        kbd_dd = 1'b1;
        repeat (24) @(negedge clk);
        model_byte(b, !bad);
        $display("frame %s code=0x%02h bad=%0d queued=%0d", tag, b, bad, m_q.size());
        check_all(tag);
    endtask

    task automatic pop(input string tag);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
        @(negedge clk);
        $display("pop %s remaining=%0d", tag, m_q.size());
        check_all(tag);
    endtask

    task automatic clear_errors(input string tag);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ovf = 0; m_perr = 0;
        @(negedge clk);
        $display("clr_err %s", tag);
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        int n;
        n = m_q.size();
        for (int i = 0; i < n; i++) pop(tag);
    endtask

    logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'hFA, 8'h12, 8'h14, 8'h11, 8'h07, 8'h71, 8'h59, 8'h1C};
    logic [7:0] ovf_codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    initial begin
        model_reset();
        repeat (4) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        int_ena = 1'b1;
        repeat (4) @(negedge clk);

        send_frame("basic", 8'h1C, 0);
        pop("basic_rd");
        pop("rd_empty");

        send_frame("pfx_e0", 8'hE0, 0);
        send_frame("pfx_f0", 8'hF0, 0);
        send_frame("pfx_75", 8'h75, 0);
        drain("pfx_drain");

        send_frame("mod_ctrl", 8'h14, 0);
        send_frame("mod_alt", 8'h11, 0);
        send_frame("mod_e0", 8'hE0, 0);
        send_frame("mod_del", 8'h71, 0);
        send_frame("rel_e0", 8'hE0, 0);
        send_frame("rel_f0", 8'hF0, 0);
        send_frame("rel_del", 8'h71, 0);
        drain("mod_drain");

        send_frame("perr_e0", 8'hE0, 0);
        send_frame("perr_bad", 8'($urandom_range(0, 255)), 1);
        send_frame("perr_1c", 8'h1C, 0);
        clear_errors("perr_clr");
        drain("perr_drain");

        for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
        repeat (500) @(negedge clk);
        send_frame("tmo_1c", 8'h1C, 0);
        drain("tmo_drain");

        for (int i = 0; i < 30; i++) begin
            logic [7:0] c;
            c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
            int_ena = 1'($urandom_range(0, 1));
            send_frame("rand", c, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) pop("rand_rd");
            if ($urandom_range(0, 7) == 0) clear_errors("rand_clr");
        end
        int_ena = 1'b1;
        drain("rand_drain");
        clear_errors("pre_ovf_clr");

        for (int i = 0; i < 9; i++) send_frame("ovf_fill", ovf_codes[i], 0);
        int_ena = 1'b0;
        @(negedge clk);
        check_val("int_off", 32'(irq), 32'(0));
        int_ena = 1'b1;
        @(negedge clk);
        check_val("int_on", 32'(irq), 32'(1));
        drain("ovf_drain");

        send_frame("rst_a", 8'h1C, 0);
        send_frame("rst_b", 8'h2A, 0);
        for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_all("rst_mid");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_frame("post_rst", 8'h1C, 0);
        drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
Parametrised PS/2 keyboard receiver for the Sprinter core, clocked entirely from CLK42.
- Filters and samples KBD_CC/KBD_DD, frames 11-bit packets and checks start, parity and stop bits.
- Folds E0/F0 prefixes into single key events and queues them in a FIFO for CPU port reads.
- Tracks modifier/hotkey state and raises a maskable interrupt while events are pending.

Parameters:
CLK_HZ, 42000000, system clock frequency used to derive the timeout count.
FILTER_LEN, 8, CLK42 cycles KBD_CC must be stable before an edge is accepted (>=2).
TIMEOUT_US, 2000, maximum gap between PS/2 clock falls inside one frame.
FIFO_DEPTH, 8, event queue depth; power of two, >=2.

Ports:
CLK42  in  1  system clock, 42 MHz.
RST  in  1  asynchronous reset, active-high.
KBD_CC  in  1  PS/2 clock line, asynchronous.
KBD_DD  in  1  PS/2 data line, asynchronous.
RD  in  1  one-cycle pop strobe from the port decoder.
DATA  out  10  FIFO head: [9]=RELEASE, [8]=EXT, [7:0]=scan code.
VALID  out  1  FIFO not empty.
OVF  out  1  sticky: event dropped because the FIFO was full.
PERR  out  1  sticky: a frame had a start, parity or stop error.
CLR_ERR  in  1  clears OVF and PERR.
KB_CTRL, KB_ALT, KB_SH, KB_F12  out  1 each  key currently held.
KB_RESET  out  1  Ctrl+Alt+Del held.
INT_ENA  in  1  interrupt enable.
INT  out  1  interrupt request, level.

Behaviour:
- Reset: every output 0; FIFO empty; frame FSM in IDLE; prefix flags and modifier state cleared. Asserting RST mid-frame discards the partial frame.
- Input path: 2-flop synchroniser on both lines.
  - Filtered clock changes level only after FILTER_LEN consecutive equal synchronised samples.
  - A falling edge of the filtered clock is a sample event; KBD_DD (synchronised) is sampled on that cycle.
- Frame FSM:
  - IDLE: sample 0 -> DATA; sample 1 -> stay in IDLE and ignore it.
  - DATA: collect 8 bits LSB first -> PARITY.
  - PARITY: record the bit -> STOP.
  - STOP: byte is good if stop=1 and data plus parity has odd parity. Good byte -> one-cycle byte strobe. Bad byte -> set PERR and drop the byte. Either way -> IDLE.
- Timeout: a counter of CLK_HZ*TIMEOUT_US/1e6 cycles reloads on every sample event. If it expires outside IDLE, the FSM returns to IDLE and the frame is dropped silently (no PERR).
- Prefix decoder, acting on good bytes:
  - E0 sets EXT; F0 sets REL.
  - FA, EE, AA are dropped and leave the flags unchanged.
  - Any other byte pushes {REL, EXT, code}, then clears both flags.
  - E1 is passed through as an ordinary code.
  - A bad frame clears both flags.
- Modifiers, updated on each pushed event (set on make, clear on release), even when the FIFO is full:
  - Shift: 12 or 59.
  - Ctrl: 14, with or without EXT.
  - Alt: 11, with or without EXT.
  - F12: 07, no EXT.
  - Del: 71 with EXT, held internally.
  - KB_RESET = Ctrl & Alt & Del.
- Latency: VALID/DATA update exactly 2 CLK42 cycles after the stop-bit sample event.
- FIFO:
  - Circular buffer with wrapping pointers and a count of width clog2(FIFO_DEPTH)+1.
  - DATA shows the head entry combinationally from registered state.
  - Push when full: the new event is lost and OVF is set.
  - RD when empty: ignored.
  - Push and RD in the same cycle when full: both happen, OVF unchanged.
  - Push and RD in the same cycle when empty: push only.
- CLR_ERR in the same cycle as a new error: the error wins and the flag stays set.
- INT: registered, INT = INT_ENA & VALID. Deasserting INT_ENA clears INT on the next CLK42 edge.

Decomposition:
- Package ps2_pkg holds:
  - the event typedef (rel, ext, code[7:0]);
  - constants for the prefix codes E0, F0 and the dropped codes FA, EE, AA;
  - modifier scan codes 12, 59, 14, 11, 07, 71.
- Sub-module ps2_frame_rx contains the synchroniser, filter, timeout and frame FSM, and outputs a byte strobe plus an error strobe.
- The FIFO and the prefix/modifier logic stay in ps2_scan_rx.

Test Plan:
- Send frame 1C with correct parity -> after 2 cycles VALID=1, DATA=0x01C; one RD pulse -> VALID=0.
- Send E0,F0,75 -> exactly one event DATA=0x375; no event is produced for E0 or F0 alone.
- Make 14, make 11, E0 71 -> KB_RESET=1 and KB_CTRL=1; send E0 F0 71 -> KB_RESET=0 while KB_CTRL stays 1.
- Send a frame with a flipped parity bit, then 1C -> PERR=1, only 0x01C is queued; CLR_ERR -> PERR=0.
- Send 4 bits, then stop the clock for longer than TIMEOUT_US, then send 1C -> no PERR, DATA=0x01C.
- Push FIFO_DEPTH+1 events without RD -> OVF=1 and the first FIFO_DEPTH events read back in order. Also check INT tracks INT_ENA & VALID, and that RST mid-frame empties the FIFO.
